regfile_fp_sb: RTL
==================

Name: regfile_fp_sb

Overview:
- Parametrised floating-point register file, successor to the fixed 32x32, 2-read/1-write FP bank.
- Adds configurable width, depth and read-port count, plus a second write port for long-latency units (FDIV/FSQRT).
- Adds a per-register busy scoreboard with a reservation handshake and optional write-to-read bypass.
- Sits between FP decode/issue (reads, reservations) and the FP execute/writeback stages.

Parameters:
- XLEN, 32, data width per register (32 = single, 64 = double).
- NREGS, 32, number of registers; power of two, at least 2.
- NRD, 3, number of read ports (3 covers FMA rs1/rs2/rs3).
- BYPASS, 1, 1 = a read of an address written this cycle returns the write data combinationally.
- ZERO_R0, 0, 1 = register 0 is hardwired to zero.
- AW, $clog2(NREGS), address width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NRD*AW  packed read addresses; port k occupies [k*AW +: AW]
- rd_data  out  NRD*XLEN  packed read data; combinational
- rd_busy  out  NRD  busy bit of each addressed register; combinational
- wr0_en  in  1  fast writeback enable (single-cycle FP ops)
- wr0_addr  in  AW  fast writeback address
- wr0_data  in  XLEN  fast writeback data
- wr1_en  in  1  long-latency writeback enable; also clears busy
- wr1_addr  in  AW  long-latency writeback address
- wr1_data  in  XLEN  long-latency writeback data
- rsv_valid  in  1  issue requests reservation of rsv_addr
- rsv_addr  in  AW  register to reserve
- rsv_ready  out  1  reservation can be accepted this cycle
- flush  in  1  synchronous clear of all busy bits
- err_collision  out  1  registered 1-cycle pulse: wr0 and wr1 hit the same address
- err_spurious  out  1  registered 1-cycle pulse: wr1 targeted a non-busy register

Behaviour:
- Reset (rst_n = 0, async): all registers = 0, all busy = 0, err_collision = 0, err_spurious = 0. rd_data therefore reads 0.
- Writes take effect at the rising clk edge; readback of the registered value is one cycle later.
- wr0 and wr1 at different addresses both commit.
- wr0 and wr1 at the same address: wr1 data wins and err_collision pulses on the next cycle.
- wr0 to a busy register is accepted; the data is written and busy is unchanged.
- wr1 clears busy[wr1_addr] at the same edge it writes.
- wr1 to a non-busy register: data is still written and err_spurious pulses.
- Reads: rd_data[k] = reg[rd_addr[k]].
- If BYPASS = 1 and the address matches an enabled write this cycle, rd_data returns that write data, with wr1 taking priority over wr0.
- rd_busy[k] = busy[rd_addr[k]] from the registered value; it is not bypassed.
- rsv_ready = !busy[rsv_addr] (registered busy only).
- A handshake is rsv_valid && rsv_ready; it sets busy[rsv_addr] at the next edge.
- Reservation and wr1 clear on the same address in the same cycle cannot occur, since rsv_ready is 0 while busy.
- flush clears all busy bits at the edge and has priority over a same-cycle reservation (that reservation is dropped).
- flush does not block writes: a wr1 in the flush cycle still writes its data and raises no err_spurious.
- ZERO_R0 = 1:
  - reg 0 always reads 0, including via bypass.
  - Writes to reg 0 are ignored and raise no error flags.
  - A reservation of reg 0 is accepted (rsv_ready = 1) but sets no busy bit.
- An address at or above NREGS cannot occur (NREGS is a power of two).
- Reset asserted mid-operation: all state clears immediately; the first edge after deassertion behaves as a fresh start.

Decomposition:
- Package fp_rf_pkg holds:
  - default XLEN and NREGS constants;
  - a typedef for the packed read-port bundle;
  - a one-hot decode function addr -> NREGS-bit vector.
- Sub-module fp_scoreboard owns the busy vector, rsv_ready, flush and err_spurious.
- Storage, write priority, bypass and err_collision stay in the top module.

Test Plan:
- Reset, then XLEN = 32, wr0 reg 5 = 0x3F800000 → the next cycle rd_addr[0] = 5 reads 0x3F800000; rd_busy[0] = 0.
- BYPASS = 1: in the same cycle wr0 reg 7 = 0x40000000 and rd_addr[1] = 7 → rd_data[1] = 0x40000000 combinationally. With BYPASS = 0 → old value 0.
- Reserve reg 9 (rsv_valid = 1, rsv_ready = 1) → the next cycle rsv_ready = 0 for addr 9 and rd_busy = 1. Then wr1 reg 9 = 0xC0490FDB → the next cycle busy = 0 and data = 0xC0490FDB.
- wr0 and wr1 both to reg 3 (0x11111111 / 0x22222222) → reg 3 = 0x22222222 and err_collision is high for exactly 1 cycle. Then wr1 reg 4 while not busy → err_spurious pulses once.
- Reserve regs 1, 2, 3, then flush with a same-cycle rsv of reg 4 → all busy = 0, including reg 4.
- ZERO_R0 = 1, wr0 reg 0 = 0xFFFFFFFF → reads 0 and no error flags. Then assert rst_n = 0 mid-burst → all reads 0 and all busy 0 before the next edge.

Source files
------------

// File: rtl/fp_rf_pkg.sv
// fp_rf_pkg: shared constants, read-port bundle types and the address
// decoder for the FP register file slice.
//   XLEN_DEF / NREGS_DEF / NRD_DEF : default geometry
//   rdAddrBundle_t / rdDataBundle_t : packed read-port bundles (port k in slot k)
//   oneHot()                        : address -> one-hot register select
package fp_rf_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned NRD_DEF   = 3;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

    // Decoder is sized for the largest supported bank; callers cast the
    // result down to their own NREGS.
    localparam int unsigned DEC_AW = 10;
    localparam int unsigned DEC_N  = 1 << DEC_AW;

    typedef logic [NRD_DEF-1:0][AW_DEF-1:0]   rdAddrBundle_t;
    typedef logic [NRD_DEF-1:0][XLEN_DEF-1:0] rdDataBundle_t;

    function automatic logic [DEC_N-1:0] oneHot(input logic [DEC_AW-1:0] addr);
        logic [DEC_N-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// fp_scoreboard: per-register busy bits with reservation handshake.
//   rsvValid/rsvAddr/rsvReady : issue-side reservation (ready = !busy)
//   clrEn/clrAddr             : long-latency writeback, clears busy
//   flush                     : clears every busy bit, drops same-cycle reservation
//   busy                      : registered busy vector
//   errSpurious               : 1-cycle pulse, writeback to a non-busy register
module fp_scoreboard
    import fp_rf_pkg::*;
#(
    parameter int NREGS   = NREGS_DEF,
    parameter int AW      = $clog2(NREGS),
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rsvValid,
    input  logic [AW-1:0]    rsvAddr,
    output logic             rsvReady,
    input  logic             clrEn,
    input  logic [AW-1:0]    clrAddr,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic             errSpurious
);

    logic             rsvTake;
    logic [NREGS-1:0] setMask;
    logic [NREGS-1:0] clrMask;

    always_comb begin
        rsvReady = !busy[rsvAddr];
        // A hardwired-zero r0 is accepted but never tracked.
        rsvTake  = rsvValid && rsvReady && !(ZERO_R0 != 0 && rsvAddr == '0);
        setMask  = rsvTake ? NREGS'(oneHot(DEC_AW'(rsvAddr))) : '0;
        clrMask  = clrEn   ? NREGS'(oneHot(DEC_AW'(clrAddr))) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            errSpurious <= 1'b0;
        end else begin
            errSpurious <= clrEn && !busy[clrAddr] && !flush;
            if (flush) busy <= '0;
            else       busy <= (busy & ~clrMask) | setMask;
        end
    end

endmodule

// File: rtl/regfile_fp_sb.sv
// regfile_fp_sb: parametrised FP register file with busy scoreboard.
//   rd_addr/rd_data/rd_busy : NRD combinational read ports (port k at slot k)
//   wr0_*                   : fast writeback port
//   wr1_*                   : long-latency writeback, wins on collision, clears busy
//   rsv_valid/rsv_addr/rsv_ready : reservation handshake
//   flush                   : clears all busy bits
//   err_collision / err_spurious : registered 1-cycle error pulses
module regfile_fp_sb
    import fp_rf_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREGS   = NREGS_DEF,
    parameter int NRD     = NRD_DEF,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0,
    parameter int AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wr0_en,
    input  logic [AW-1:0]     wr0_addr,
    input  logic [XLEN-1:0]   wr0_data,
    input  logic              wr1_en,
    input  logic [AW-1:0]     wr1_addr,
    input  logic [XLEN-1:0]   wr1_data,
    input  logic              rsv_valid,
    input  logic [AW-1:0]     rsv_addr,
    output logic              rsv_ready,
    input  logic              flush,
    output logic              err_collision,
    output logic              err_spurious
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             we0;
    logic             we1;
    logic [AW-1:0]    rdA;
    logic [XLEN-1:0]  rdD;

    // Writes to a hardwired r0 are dropped here so they never reach
    // storage, bypass, or the error flags.
    assign we0 = wr0_en && !(ZERO_R0 != 0 && wr0_addr == '0);
    assign we1 = wr1_en && !(ZERO_R0 != 0 && wr1_addr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
            err_collision <= 1'b0;
        end else begin
            // wr1 is assigned last so it wins a same-address collision.
            if (we0) regs[wr0_addr] <= wr0_data;
            if (we1) regs[wr1_addr] <= wr1_data;
            err_collision <= we0 && we1 && (wr0_addr == wr1_addr);
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rdA     = '0;
        rdD     = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            rdA = rd_addr[k*AW +: AW];
            rdD = regs[rdA];
            if (BYPASS != 0) begin
                if (we0 && wr0_addr == rdA) rdD = wr0_data;
                if (we1 && wr1_addr == rdA) rdD = wr1_data;
            end
            rd_data[k*XLEN +: XLEN] = rdD;
            rd_busy[k]              = busy[rdA];
        end
    end

    fp_scoreboard #(
        .NREGS   (NREGS),
        .AW      (AW),
        .ZERO_R0 (ZERO_R0)
    ) uScoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .rsvValid    (rsv_valid),
        .rsvAddr     (rsv_addr),
        .rsvReady    (rsv_ready),
        .clrEn       (we1),
        .clrAddr     (wr1_addr),
        .flush       (flush),
        .busy        (busy),
        .errSpurious (err_spurious)
    );

endmodule
